// File: rtl/uart_pkg.sv
// Shared UART definitions: TX arbiter state encoding, header default and
// the width helper used by the UART FIFOs and arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, scanning
// upward modulo N, returned one-hot.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             found_o
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(ptr_i) + i) % N;
            if (!found && req_i[IDX_W'(idx)]) begin
                grant_o[IDX_W'(idx)] = 1'b1;
                found                = 1'b1;
            end
        end
        found_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX FIFO write port
// among NUM_REQ byte-stream requesters, with optional ID header byte.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          HDR_EN     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE = DATA_WIDTH'(HDR_BASE_DEFAULT),
    parameter int unsigned MAX_LEN    = 64,
    localparam int unsigned ID_W      = clog2(NUM_REQ),
    localparam int unsigned CNT_W     = clog2(MAX_LEN) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_fifo_full,
    output logic                          tx_wr_en,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          pkt_done,
    output logic                          trunc_err
);

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     pick_grant;
    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];
    logic                   at_max;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .found_o (pick_found)
    );

    always_comb begin
        pick_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_id = ID_W'(i);
            end
        end
    end

    assign at_max   = (cnt_q == CNT_W'(MAX_LEN - 1));
    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

    // Next state and write-port outputs; only the granted requester is observed.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tx_wr_en  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        pkt_done  = 1'b0;
        trunc_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_id;
                    cnt_d   = '0;
                    state_d = HDR_EN ? ST_HDR : ST_DATA;
                end
            end
            ST_HDR: begin
                tx_data = HDR_BASE | DATA_WIDTH'(grant_q);
                if (!tx_fifo_full) begin
                    tx_wr_en = 1'b1;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (req_valid[grant_q] && !tx_fifo_full) begin
                    tx_wr_en           = 1'b1;
                    req_ready[grant_q] = 1'b1;
                    tx_data            = req_bytes[grant_q];
                    cnt_d              = cnt_q + CNT_W'(1);
                    if (req_last[grant_q] || at_max) begin
                        pkt_done  = 1'b1;
                        trunc_err = at_max && !req_last[grant_q];
                        ptr_d     = grant_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets, expected FIFO
// writes queued at issue time and checked by an independent monitor.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             tx_fifo_full;
    logic             tx_wr_en;
    logic [DW-1:0]    tx_data;
    logic [1:0]       grant_id;
    logic             busy;
    logic             pkt_done;
    logic             trunc_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .MAX_LEN(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_fifo_full(tx_fifo_full),
        .tx_wr_en(tx_wr_en), .tx_data(tx_data), .grant_id(grant_id),
        .busy(busy), .pkt_done(pkt_done), .trunc_err(trunc_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       done;
        logic       trunc;
        logic [1:0] gid;
        int         gap;
    } exp_t;

    exp_t       sb [$];
    logic [8:0] rq [NR][$];
    logic [NR-1:0] en;
    int pop_cnt [NR];
    int checks = 0, errors = 0, wr_cnt = 0, cyc = 0, last_wr = 0;

    function automatic void push(input logic [7:0] d, input logic done, input logic trunc,
                                 input logic [1:0] gid, input int gap);
        exp_t e;
        e.data = d; e.done = done; e.trunc = trunc; e.gid = gid; e.gap = gap;
        sb.push_back(e);
    endfunction

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk(name, 32'({tx_wr_en, req_ready, busy, pkt_done, trunc_err, tx_data, grant_id}), 32'd0);
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d writes outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_pop(input string name, input int r, input int start, input int max);
        int n = 0;
        while (pop_cnt[r] == start && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (pop_cnt[r] == start) begin
            errors++;
            $display("FAIL %s: requester %0d byte never consumed", name, r);
        end
    endtask

    // Requester models: consume on ready&valid, then present the next queued byte.
    initial begin
        logic [NR-1:0] fire;
        logic [8:0]    h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i] && rq[i].size() != 0) begin
                    void'(rq[i].pop_front());
                    pop_cnt[i]++;
                end
            end
            #2;
            for (int i = 0; i < NR; i++) begin
                if (en[i] && rq[i].size() != 0) begin
                    h = rq[i][0];
                    req_valid[i]         = 1'b1;
                    req_data[i*DW +: DW] = h[7:0];
                    req_last[i]          = h[8];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_last[i]          = 1'b0;
                end
            end
        end
    end

    // Monitor: every FIFO write is popped against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (tx_fifo_full) begin
            checks++;
            if (tx_wr_en || req_ready != '0) begin
                errors++;
                $display("FAIL stall_hold: tx_wr_en=%0b req_ready=%b, required 0 and 0000",
                         tx_wr_en, req_ready);
            end
        end
        if (tx_wr_en) begin
            wr_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: data=%h grant=%0d", tx_data, grant_id);
            end else begin
                e = sb.pop_front();
                if ({tx_data, pkt_done, trunc_err, grant_id} !== {e.data, e.done, e.trunc, e.gid}) begin
                    errors++;
                    $display("FAIL write_%0d: data=%h done=%0b trunc=%0b gid=%0d, required data=%h done=%0b trunc=%0b gid=%0d",
                             wr_cnt, tx_data, pkt_done, trunc_err, grant_id,
                             e.data, e.done, e.trunc, e.gid);
                end
                if (e.gap >= 0) begin
                    checks++;
                    if (cyc - last_wr - 1 != e.gap) begin
                        errors++;
                        $display("FAIL gap_before_%h: %0d idle cycles, required %0d",
                                 e.data, cyc - last_wr - 1, e.gap);
                    end
                end
            end
            last_wr = cyc;
        end else begin
            checks++;
            if (pkt_done || trunc_err) begin
                errors++;
                $display("FAIL pulse_without_write: pkt_done=%0b trunc_err=%0b, required 0 0",
                         pkt_done, trunc_err);
            end
        end
    end

    initial begin
        int start;
        rst          = 1'b0;
        tx_fifo_full = 1'b0;
        en           = '0;
        tick();
        tick();
        chk_reset("reset_state");
        rst = 1'b1;
        tick();

        // Single packet from requester 0.
        push(8'hA0, 0, 0, 2'd0, -1);
        push(8'h11, 0, 0, 2'd0, 0);
        push(8'h22, 0, 0, 2'd0, 0);
        push(8'h33, 1, 0, 2'd0, 0);
        load(0, 8'h11, 0); load(0, 8'h22, 0); load(0, 8'h33, 1);
        en = 4'b0001;
        wait_drain("t1_drain", 50);
        chk("t1_grant_id", 32'(grant_id), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        rst = 1'b0;
        tick();
        chk_reset("reset_between");
        rst = 1'b1;

        // All requesters contending with one-byte packets, two rounds.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                push(8'hA0 | 8'(i), 0, 0, 2'(i), (r == 0 && i == 0) ? -1 : 1);
                push(8'(16 * (r + 1) + i), 1, 0, 2'(i), 0);
                load(i, 8'(16 * (r + 1) + i), 1);
            end
        end
        en = 4'b1111;
        wait_drain("t2_drain", 100);

        // FIFO full stall right after requester 2's header.
        push(8'hA2, 0, 0, 2'd2, -1);
        push(8'h05, 0, 0, 2'd2, 3);
        push(8'h06, 0, 0, 2'd2, 0);
        push(8'h07, 1, 0, 2'd2, 0);
        start = wr_cnt;
        load(2, 8'h05, 0); load(2, 8'h06, 0); load(2, 8'h07, 1);
        begin
            int n = 0;
            while (wr_cnt == start && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t3_header_seen", 32'(wr_cnt - start), 32'd1);
        tx_fifo_full = 1'b1;
        repeat (3) tick();
        tx_fifo_full = 1'b0;
        wait_drain("t3_drain", 50);

        // Requester 1 pauses mid-packet; requester 3 must wait for its last byte.
        push(8'hA1, 0, 0, 2'd1, -1);
        push(8'h41, 0, 0, 2'd1, 0);
        push(8'h42, 0, 0, 2'd1, 4);
        push(8'h43, 1, 0, 2'd1, 0);
        push(8'hA3, 0, 0, 2'd3, 1);
        push(8'h31, 0, 0, 2'd3, 0);
        push(8'h32, 1, 0, 2'd3, 0);
        start = pop_cnt[1];
        load(1, 8'h41, 0); load(1, 8'h42, 0); load(1, 8'h43, 1);
        wait_pop("t4_first_byte", 1, start, 30);
        en[1] = 1'b0;
        load(3, 8'h31, 0); load(3, 8'h32, 1);
        repeat (4) tick();
        en[1] = 1'b1;
        wait_drain("t4_drain", 50);

        // MAX_LEN=4 truncation; the tail forms the next packet.
        push(8'hA0, 0, 0, 2'd0, -1);
        push(8'h01, 0, 0, 2'd0, 0);
        push(8'h02, 0, 0, 2'd0, 0);
        push(8'h03, 0, 0, 2'd0, 0);
        push(8'h04, 1, 1, 2'd0, 0);
        push(8'hA0, 0, 0, 2'd0, 1);
        push(8'h05, 0, 0, 2'd0, 0);
        push(8'h06, 1, 0, 2'd0, 0);
        for (int b = 1; b <= 6; b++) load(0, 8'(b), (b == 6));
        wait_drain("t5_drain", 60);

        // Reset mid-packet of requester 3; requester 0 wins afterwards.
        push(8'hA3, 0, 0, 2'd3, -1);
        push(8'h71, 0, 0, 2'd3, 0);
        push(8'hA0, 0, 0, 2'd0, -1);
        push(8'h99, 1, 0, 2'd0, 0);
        push(8'hA3, 0, 0, 2'd3, 1);
        push(8'h72, 0, 0, 2'd3, 0);
        push(8'h73, 1, 0, 2'd3, 0);
        start = pop_cnt[3];
        load(3, 8'h71, 0); load(3, 8'h72, 0); load(3, 8'h73, 1);
        wait_pop("t6_first_byte", 3, start, 30);
        load(0, 8'h99, 1);
        rst = 1'b0;
        #2;
        chk_reset("t6_reset_mid_packet");
        tick();
        rst = 1'b1;
        wait_drain("t6_drain", 60);
        tick();
        chk("final_grant_id", 32'(grant_id), 32'd3);
        chk("final_busy", 32'(busy), 32'd0);
        chk("requesters_drained",
            32'(rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
